// File: rtl/bullet_hit_scheduler_if.sv
// Bus bundle between the game logic and the bullet hit scheduler.
// The game logic (master) drives player/bullet state and frame pulses.
// The scheduler (slave) returns kill requests and player status.
interface bullet_hit_scheduler_if #(
  parameter int N_SLOTS = 4
);
  logic                    frame_tick;
  logic                    new_game;
  logic [9:0]              p_x;
  logic [9:0]              p_y;
  logic                    player_en;
  logic [10*N_SLOTS-1:0]   eb_x;
  logic [10*N_SLOTS-1:0]   eb_y;
  logic [N_SLOTS-1:0]      eb_en;
  logic [N_SLOTS-1:0]      kill_req;
  logic [3:0]              health;
  logic                    hit_pulse;
  logic                    invuln;
  logic                    boom;
  logic                    scan_busy;
  logic                    scan_done;
  logic                    overrun;

  modport master (
    output frame_tick, new_game, p_x, p_y, player_en, eb_x, eb_y, eb_en,
    input  kill_req, health, hit_pulse, invuln, boom, scan_busy, scan_done, overrun
  );

  modport slave (
    input  frame_tick, new_game, p_x, p_y, player_en, eb_x, eb_y, eb_en,
    output kill_req, health, hit_pulse, invuln, boom, scan_busy, scan_done, overrun
  );
endinterface

// File: rtl/bullet_hit_scheduler.sv
// Bullet hit scheduler: once per frame, walks the enemy-bullet slots one per
// cycle through a single shared hit-box comparator, requests removal of any
// bullet touching the player, and manages health, invulnerability and boom.
module bullet_hit_scheduler #(
  parameter int N_SLOTS       = 4,
  parameter int INIT_HEALTH   = 3,
  parameter int INVULN_FRAMES = 30
) (
  input  logic                         clk,
  input  logic                         rst,
  bullet_hit_scheduler_if.slave        bus
);

  localparam int IDX_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam int CNT_W = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_SLOTS - 1);
  localparam logic [3:0]       INIT_H      = 4'(INIT_HEALTH);
  localparam logic [CNT_W-1:0] INVULN_LOAD = CNT_W'(INVULN_FRAMES);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   slotIdx_q, slotIdx_d;
  logic [3:0]         health_q, health_d;
  logic [CNT_W-1:0]   invCnt_q, invCnt_d;
  logic               boom_q, boom_d;
  logic               accepted_q, accepted_d;
  logic [N_SLOTS-1:0] killReq_q, killReq_d;
  logic               hitPulse_q, hitPulse_d;
  logic               overrun_q, overrun_d;

  logic [9:0]         ebX [N_SLOTS];
  logic [9:0]         ebY [N_SLOTS];
  logic [10:0]        selX, selY, pX, pY;
  logic               overlap;
  logic               candidate;
  logic               invulnNow;

  for (genvar g = 0; g < N_SLOTS; g++) begin : g_unpack
    assign ebX[g] = bus.eb_x[10*g+9 : 10*g];
    assign ebY[g] = bus.eb_y[10*g+9 : 10*g];
  end

  assign invulnNow = (invCnt_q != '0);

  // Single hit-box comparator, fed by the slot currently selected by the scan index.
  always_comb begin
    selX = {1'b0, ebX[slotIdx_q]};
    selY = {1'b0, ebY[slotIdx_q]};
    pX   = {1'b0, bus.p_x};
    pY   = {1'b0, bus.p_y};
    overlap = (pX + 11'd10 >= selX) && (pX < selX + 11'd50) &&
              (pY + 11'd50 >= selY) && (pY < selY + 11'd40);
    candidate = (state_q == SCAN) && bus.eb_en[slotIdx_q] && bus.player_en &&
                (health_q != 4'd0) && !boom_q && overlap;
  end

  // Next-state logic for the scan FSM, health, invulnerability and pulse outputs.
  always_comb begin
    state_d    = state_q;
    slotIdx_d  = slotIdx_q;
    health_d   = health_q;
    invCnt_d   = invCnt_q;
    boom_d     = boom_q | (health_q == 4'd0);
    accepted_d = accepted_q;
    killReq_d  = '0;
    hitPulse_d = 1'b0;
    overrun_d  = bus.frame_tick && (state_q != IDLE);

    if (bus.frame_tick && invulnNow) begin
      invCnt_d = invCnt_q - CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (bus.frame_tick) begin
          state_d    = SCAN;
          slotIdx_d  = '0;
          accepted_d = 1'b0;
        end
      end
      SCAN: begin
        if (candidate) begin
          killReq_d[slotIdx_q] = 1'b1;
          if (!invulnNow && !accepted_q) begin
            health_d   = health_q - 4'd1;
            hitPulse_d = 1'b1;
            invCnt_d   = INVULN_LOAD;
            accepted_d = 1'b1;
          end
        end
        if (slotIdx_q == LAST_IDX) begin
          state_d   = DONE;
          slotIdx_d = '0;
        end else begin
          slotIdx_d = slotIdx_q + IDX_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (bus.new_game) begin
      state_d    = IDLE;
      slotIdx_d  = '0;
      health_d   = INIT_H;
      invCnt_d   = '0;
      boom_d     = 1'b0;
      accepted_d = 1'b0;
      killReq_d  = '0;
      hitPulse_d = 1'b0;
    end
  end

  // State registers; reset aborts any scan in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      slotIdx_q  <= '0;
      health_q   <= INIT_H;
      invCnt_q   <= '0;
      boom_q     <= 1'b0;
      accepted_q <= 1'b0;
      killReq_q  <= '0;
      hitPulse_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      slotIdx_q  <= slotIdx_d;
      health_q   <= health_d;
      invCnt_q   <= invCnt_d;
      boom_q     <= boom_d;
      accepted_q <= accepted_d;
      killReq_q  <= killReq_d;
      hitPulse_q <= hitPulse_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.kill_req  = killReq_q;
  assign bus.health    = health_q;
  assign bus.hit_pulse = hitPulse_q;
  assign bus.invuln    = invulnNow;
  assign bus.boom      = boom_q;
  assign bus.scan_busy = (state_q == SCAN) || (state_q == DONE);
  assign bus.scan_done = (state_q == DONE);
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_bullet_hit_scheduler.sv
// Directed testbench for bullet_hit_scheduler with hand-computed expectations.
module tb_bullet_hit_scheduler;

  logic clk;
  logic rst;
  int   checkCount;
  int   failCount;

  logic [3:0] killLog   [1:6];
  logic [3:0] healthLog [1:6];
  logic       hitLog    [1:6];
  logic       busyLog   [1:6];
  logic       doneLog   [1:6];
  logic       invLog    [1:6];
  logic       boomLog   [1:6];
  logic [3:0] killAny;

  int edgeX   [10] = '{110, 111, 51, 50, 100, 100, 100, 100, 110, 110};
  int edgeY   [10] = '{180, 180, 180, 200, 250, 251, 161, 160, 180, 180};
  bit edgeEn  [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1};
  bit edgePen [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  bit edgeHit [10] = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 0};

  bullet_hit_scheduler_if #(.N_SLOTS(4)) bus ();

  bullet_hit_scheduler #(
    .N_SLOTS(4),
    .INIT_HEALTH(3),
    .INVULN_FRAMES(30)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int px, input int py, input bit pen, input logic [3:0] en);
    bus.p_x       = 10'(px);
    bus.p_y       = 10'(py);
    bus.player_en = pen;
    bus.eb_en     = en;
  endtask

  task automatic placeBullet(input int slot, input int x, input int y);
    bus.eb_x[slot*10 +: 10] = 10'(x);
    bus.eb_y[slot*10 +: 10] = 10'(y);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Pulses frame_tick in cycle T and logs outputs for cycles T+1..T+6.
  task automatic pulseFrame();
    bus.frame_tick = 1'b1;
    killAny = '0;
    for (int k = 1; k <= 6; k++) begin
      nextCycle();
      if (k == 1) bus.frame_tick = 1'b0;
      killLog[k]   = bus.kill_req;
      healthLog[k] = bus.health;
      hitLog[k]    = bus.hit_pulse;
      busyLog[k]   = bus.scan_busy;
      doneLog[k]   = bus.scan_done;
      invLog[k]    = bus.invuln;
      boomLog[k]   = bus.boom;
      killAny      = killAny | bus.kill_req;
    end
  endtask

  task automatic ageFrames(input int n);
    bus.eb_en = '0;
    for (int j = 0; j < n; j++) pulseFrame();
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    rst = 1'b1;
    bus.frame_tick = 1'b0;
    bus.new_game   = 1'b0;
    bus.eb_x = '0;
    bus.eb_y = '0;
    applyStimulus(100, 200, 1'b1, 4'b0000);
    repeat (2) nextCycle();

    checkOutput("rst_health", 32'(bus.health), 32'd3);
    checkOutput("rst_kill", 32'(bus.kill_req), 32'd0);
    checkOutput("rst_flags", 32'({bus.hit_pulse, bus.invuln, bus.boom, bus.scan_busy, bus.scan_done, bus.overrun}), 32'd0);
    rst = 1'b0;
    nextCycle();

    // Slot 2 hit with player at (100,200), bullet on the x edge p_x+10 == eb_x
    placeBullet(2, 110, 180);
    applyStimulus(100, 200, 1'b1, 4'b0100);
    pulseFrame();
    checkOutput("a_kill_t3", 32'(killLog[3]), 32'd0);
    checkOutput("a_kill_t4", 32'(killLog[4]), 32'b0100);
    checkOutput("a_hit_t4", 32'(hitLog[4]), 32'd1);
    checkOutput("a_health_t3", 32'(healthLog[3]), 32'd3);
    checkOutput("a_health_t4", 32'(healthLog[4]), 32'd2);
    checkOutput("a_inv_t4", 32'(invLog[4]), 32'd1);
    checkOutput("a_busy_t1", 32'(busyLog[1]), 32'd1);
    checkOutput("a_done_t4", 32'(doneLog[4]), 32'd0);
    checkOutput("a_done_t5", 32'(doneLog[5]), 32'd1);
    checkOutput("a_busy_t6", 32'(busyLog[6]), 32'd0);
    placeBullet(2, 0, 0);

    // Hit-box edges on slot 1 while invulnerable: kill pulses, no damage
    for (int i = 0; i < 10; i++) begin
      applyStimulus(100, 200, edgePen[i], edgeEn[i] ? 4'b0010 : 4'b0000);
      placeBullet(1, edgeX[i], edgeY[i]);
      pulseFrame();
      checkOutput($sformatf("edge%0d_kill", i), 32'(killAny), edgeHit[i] ? 32'b0010 : 32'd0);
      checkOutput($sformatf("edge%0d_hit", i), 32'(hitLog[3]), 32'd0);
    end
    checkOutput("edge_health", 32'(bus.health), 32'd2);
    placeBullet(1, 0, 0);

    // Counter was 30 after hit A, 10 edge frames aged it to 20
    ageFrames(19);
    checkOutput("age_inv_one", 32'(bus.invuln), 32'd1);
    ageFrames(1);
    checkOutput("age_inv_zero", 32'(bus.invuln), 32'd0);

    // Slots 0 and 3 both overlap: only the first one damages
    placeBullet(0, 100, 200);
    placeBullet(3, 60, 170);
    applyStimulus(100, 200, 1'b1, 4'b1001);
    pulseFrame();
    checkOutput("b_kill_t2", 32'(killLog[2]), 32'b0001);
    checkOutput("b_hit_t2", 32'(hitLog[2]), 32'd1);
    checkOutput("b_health_t2", 32'(healthLog[2]), 32'd1);
    checkOutput("b_kill_t5", 32'(killLog[5]), 32'b1000);
    checkOutput("b_hit_t5", 32'(hitLog[5]), 32'd0);
    checkOutput("b_health_t5", 32'(healthLog[5]), 32'd1);

    // Second frame_tick two cycles into a scan is ignored and flagged
    bus.eb_en = '0;
    bus.frame_tick = 1'b1;
    nextCycle();
    bus.frame_tick = 1'b0;
    checkOutput("ovr_t1", 32'(bus.overrun), 32'd0);
    nextCycle();
    bus.frame_tick = 1'b1;
    nextCycle();
    bus.frame_tick = 1'b0;
    checkOutput("ovr_t3", 32'(bus.overrun), 32'd1);
    nextCycle();
    checkOutput("ovr_t4", 32'(bus.overrun), 32'd0);
    nextCycle();
    checkOutput("ovr_done_t5", 32'(bus.scan_done), 32'd1);
    nextCycle();
    checkOutput("ovr_busy_t6", 32'(bus.scan_busy), 32'd0);

    // Both ticks aged the counter: 30 -> 28, so 27 more frames leave 1
    ageFrames(27);
    checkOutput("ovr_inv_one", 32'(bus.invuln), 32'd1);
    ageFrames(1);
    checkOutput("ovr_inv_zero", 32'(bus.invuln), 32'd0);

    // Third accepted hit kills the player, boom follows a cycle later
    applyStimulus(100, 200, 1'b1, 4'b0001);
    pulseFrame();
    checkOutput("c_health_t2", 32'(healthLog[2]), 32'd0);
    checkOutput("c_hit_t2", 32'(hitLog[2]), 32'd1);
    checkOutput("c_boom_t2", 32'(boomLog[2]), 32'd0);
    checkOutput("c_boom_t3", 32'(boomLog[3]), 32'd1);
    pulseFrame();
    checkOutput("c_dead_kill", 32'(killAny), 32'd0);
    checkOutput("c_dead_health", 32'(bus.health), 32'd0);
    checkOutput("c_dead_boom", 32'(bus.boom), 32'd1);

    // new_game restores health and clears boom
    bus.new_game = 1'b1;
    nextCycle();
    bus.new_game = 1'b0;
    checkOutput("ng_health", 32'(bus.health), 32'd3);
    checkOutput("ng_boom", 32'(bus.boom), 32'd0);
    checkOutput("ng_inv", 32'(bus.invuln), 32'd0);

    // new_game in slot 0's examination cycle cancels the hit and the scan
    bus.frame_tick = 1'b1;
    nextCycle();
    bus.frame_tick = 1'b0;
    bus.new_game = 1'b1;
    nextCycle();
    bus.new_game = 1'b0;
    checkOutput("ngo_kill", 32'(bus.kill_req), 32'd0);
    checkOutput("ngo_hit", 32'(bus.hit_pulse), 32'd0);
    checkOutput("ngo_health", 32'(bus.health), 32'd3);
    checkOutput("ngo_busy", 32'(bus.scan_busy), 32'd0);

    // Reset in the middle of a scan drops the pending slot 3 kill
    applyStimulus(100, 200, 1'b1, 4'b1001);
    bus.frame_tick = 1'b1;
    nextCycle();
    bus.frame_tick = 1'b0;
    nextCycle();
    checkOutput("rs_kill_t2", 32'(bus.kill_req), 32'b0001);
    checkOutput("rs_health_t2", 32'(bus.health), 32'd2);
    rst = 1'b1;
    #1;
    checkOutput("rs_health", 32'(bus.health), 32'd3);
    checkOutput("rs_kill", 32'(bus.kill_req), 32'd0);
    checkOutput("rs_flags", 32'({bus.hit_pulse, bus.invuln, bus.boom, bus.scan_busy, bus.scan_done, bus.overrun}), 32'd0);
    #2;
    rst = 1'b0;
    killAny = '0;
    for (int k = 0; k < 5; k++) begin
      nextCycle();
      killAny = killAny | bus.kill_req;
    end
    checkOutput("rs_no_kill", 32'(killAny), 32'd0);
    checkOutput("rs_idle", 32'(bus.scan_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
